// File: rtl/ray_dispatcher_if.sv
// ray_dispatcher_if
//   Result stream from ray_dispatcher to the downstream shader/writer.
//   One record per pixel, transferred on a valid/ready handshake.
//
//   o_res_valid      record valid (dispatcher -> downstream)
//   i_res_ready      downstream ready (downstream -> dispatcher)
//   o_res_x/o_res_y  pixel coordinates of the record
//   o_res_hit        hit flag
//   o_res_t          nearest t, 32'h7fffffff on miss
//   o_res_tri_index  index of the nearest triangle, 0 on miss
//
//   master: the dispatcher side, slave: the consumer side.
interface ray_dispatcher_if #(
  parameter int DIM_W = 16
);
  logic             o_res_valid;
  logic             i_res_ready;
  logic [DIM_W-1:0] o_res_x;
  logic [DIM_W-1:0] o_res_y;
  logic             o_res_hit;
  logic [31:0]      o_res_t;
  logic [31:0]      o_res_tri_index;

  modport master (
    output o_res_valid, o_res_x, o_res_y, o_res_hit, o_res_t, o_res_tri_index,
    input  i_res_ready
  );

  modport slave (
    input  o_res_valid, o_res_x, o_res_y, o_res_hit, o_res_t, o_res_tri_index,
    output i_res_ready
  );
endinterface

// File: rtl/ray_dispatcher.sv
// ray_dispatcher
//   Per-frame ray source in front of tri_insector. Walks a width x height
//   pixel grid in raster order (x fastest), forms one primary ray per pixel
//   by additive stepping of the direction vector, hands it to tri_insector,
//   waits for the result and forwards a per-pixel hit record downstream.
//
//   i_clk, i_rstn      clock, synchronous active-low reset
//   i_start            frame start, accepted only while idle
//   i_width/i_height   frame size, latched on accepted start
//   i_tri_cnt          triangle count, latched on accepted start
//   i_eye/i_base       ray origin / direction of pixel (0,0), {z,y,x}
//   i_du/i_dv          direction step per +x / per +y, {z,y,x}
//   o_ins_valid        one-cycle issue pulse to tri_insector
//   o_ins_ray          {direction, origin} presented to tri_insector
//   o_ins_tri_cnt      triangle count presented to tri_insector
//   i_ins_*            tri_insector finish level and result
//   res                result record stream (ray_dispatcher_if.master)
//   o_busy             high whenever not idle
//   o_done             one-cycle pulse when a frame completes
//
//   Vector arithmetic is per-component 32-bit two's complement with
//   wrap-around; FRA_BITS only documents the fixed-point interpretation.
module ray_dispatcher #(
  parameter int DIM_W    = 16,
  parameter int FRA_BITS = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [DIM_W-1:0]   i_width,
  input  logic [DIM_W-1:0]   i_height,
  input  logic [31:0]        i_tri_cnt,
  input  logic [95:0]        i_eye,
  input  logic [95:0]        i_base,
  input  logic [95:0]        i_du,
  input  logic [95:0]        i_dv,
  output logic               o_ins_valid,
  output logic [191:0]       o_ins_ray,
  output logic [31:0]        o_ins_tri_cnt,
  input  logic               i_ins_finish,
  input  logic               i_ins_hit,
  input  logic [31:0]        i_ins_t,
  input  logic [31:0]        i_ins_tri_index,
  ray_dispatcher_if.master   res,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [31:0] MISS_T = 32'h7fff_ffff;

  if (FRA_BITS < 0 || FRA_BITS > 31) begin : g_fra_bits_check
    $error("ray_dispatcher: FRA_BITS must be in 0..31");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLR,
    WAIT_FIN,
    EMIT
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0] width_q, height_q;
  logic [DIM_W-1:0] x_q, y_q;
  logic [31:0]      tri_cnt_q;
  logic [95:0]      eye_q, du_q, dv_q;
  logic [95:0]      row_dir_q, cur_dir_q;
  logic             hit_q;
  logic [31:0]      t_q, idx_q;
  logic             done_q;

  logic             dims_ok;
  logic [DIM_W:0]   x_inc, y_inc;
  logic             more_x, more_y;

  // Per-component wrap-around add of two {z,y,x} vectors.
  function automatic logic [95:0] add3(input logic [95:0] a, input logic [95:0] b);
    add3 = {a[95:64] + b[95:64], a[63:32] + b[63:32], a[31:0] + b[31:0]};
  endfunction

  // One extra bit keeps x+1 / y+1 from wrapping when the frame spans the
  // full counter range.
  assign dims_ok = (i_width != '0) && (i_height != '0);
  assign x_inc   = {1'b0, x_q} + {{DIM_W{1'b0}}, 1'b1};
  assign y_inc   = {1'b0, y_q} + {{DIM_W{1'b0}}, 1'b1};
  assign more_x  = x_inc < {1'b0, width_q};
  assign more_y  = y_inc < {1'b0, height_q};

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. A zero triangle count bypasses tri_insector entirely,
  // since issuing to it with no triangles would underflow its counter.
  // WAIT_CLR exists because tri_insector's finish is still high from the
  // previous ray for one cycle after the issue pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start && dims_ok) state_d = (i_tri_cnt == '0) ? EMIT : ISSUE;
      end
      ISSUE:    state_d = WAIT_CLR;
      WAIT_CLR: state_d = WAIT_FIN;
      WAIT_FIN: begin
        if (i_ins_finish) state_d = EMIT;
      end
      EMIT: begin
        if (res.i_res_ready) begin
          if (!more_x && !more_y)     state_d = IDLE;
          else if (tri_cnt_q == '0)   state_d = EMIT;
          else                        state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_ins_valid     = (state_q == ISSUE);
    res.o_res_valid = (state_q == EMIT);
    o_busy          = (state_q != IDLE);
  end

  // Frame parameters, pixel walk, direction stepping and result capture.
  // The row direction is kept separately so each new row restarts from the
  // row origin rather than accumulating width*du drift.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      width_q   <= '0;
      height_q  <= '0;
      tri_cnt_q <= '0;
      eye_q     <= '0;
      du_q      <= '0;
      dv_q      <= '0;
      row_dir_q <= '0;
      cur_dir_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hit_q     <= 1'b0;
      t_q       <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (dims_ok) begin
              width_q   <= i_width;
              height_q  <= i_height;
              tri_cnt_q <= i_tri_cnt;
              eye_q     <= i_eye;
              du_q      <= i_du;
              dv_q      <= i_dv;
              row_dir_q <= i_base;
              cur_dir_q <= i_base;
              x_q       <= '0;
              y_q       <= '0;
              if (i_tri_cnt == '0) begin
                hit_q <= 1'b0;
                t_q   <= MISS_T;
                idx_q <= '0;
              end
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        WAIT_FIN: begin
          if (i_ins_finish) begin
            hit_q <= i_ins_hit;
            t_q   <= i_ins_t;
            idx_q <= i_ins_tri_index;
          end
        end
        EMIT: begin
          if (res.i_res_ready) begin
            if (more_x) begin
              x_q       <= x_inc[DIM_W-1:0];
              cur_dir_q <= add3(cur_dir_q, du_q);
            end else if (more_y) begin
              x_q       <= '0;
              y_q       <= y_inc[DIM_W-1:0];
              row_dir_q <= add3(row_dir_q, dv_q);
              cur_dir_q <= add3(row_dir_q, dv_q);
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ins_ray           = {cur_dir_q, eye_q};
  assign o_ins_tri_cnt       = tri_cnt_q;
  assign o_done              = done_q;
  assign res.o_res_x         = x_q;
  assign res.o_res_y         = y_q;
  assign res.o_res_hit       = hit_q;
  assign res.o_res_t         = t_q;
  assign res.o_res_tri_index = idx_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher
//   Self-checking bench for ray_dispatcher. A small tri_insector stub answers
//   each issued ray after a random latency with a per-pixel response chosen
//   by the bench. Expected rays come from base + x*du + y*dv per component;
//   expected records come from the stub's response table (or the forced miss
//   when the scene is empty).
module tb_ray_dispatcher;

  localparam int DIM_W = 16;
  localparam logic [31:0] MISS_T = 32'h7fff_ffff;

  logic               i_clk = 1'b0;
  logic               i_rstn;
  logic               i_start;
  logic [DIM_W-1:0]   i_width, i_height;
  logic [31:0]        i_tri_cnt;
  logic [95:0]        i_eye, i_base, i_du, i_dv;
  logic               o_ins_valid;
  logic [191:0]       o_ins_ray;
  logic [31:0]        o_ins_tri_cnt;
  logic               ins_finish, ins_hit;
  logic [31:0]        ins_t, ins_idx;
  logic               o_busy, o_done;

  int checks = 0;
  int errors = 0;

  // Stub response table, indexed by the pixel currently in flight.
  bit          resp_hit [64];
  logic [31:0] resp_t   [64];
  logic [31:0] resp_idx [64];
  int          cur_pix = 0;

  bit stub_pend;
  int stub_cnt;

  always #5 i_clk = ~i_clk;

  ray_dispatcher_if #(.DIM_W(DIM_W)) res_if ();

  ray_dispatcher #(.DIM_W(DIM_W), .FRA_BITS(16)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_start         (i_start),
    .i_width         (i_width),
    .i_height        (i_height),
    .i_tri_cnt       (i_tri_cnt),
    .i_eye           (i_eye),
    .i_base          (i_base),
    .i_du            (i_du),
    .i_dv            (i_dv),
    .o_ins_valid     (o_ins_valid),
    .o_ins_ray       (o_ins_ray),
    .o_ins_tri_cnt   (o_ins_tri_cnt),
    .i_ins_finish    (ins_finish),
    .i_ins_hit       (ins_hit),
    .i_ins_t         (ins_t),
    .i_ins_tri_index (ins_idx),
    .res             (res_if),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  // tri_insector stand-in: finish stays high one more cycle after the issue
  // pulse (stale from the previous ray), drops, then rises again with the
  // response after a random latency.
  always @(posedge i_clk) begin
    if (!i_rstn) begin
      ins_finish <= 1'b1;
      ins_hit    <= 1'b0;
      ins_t      <= '0;
      ins_idx    <= '0;
      stub_pend  <= 1'b0;
      stub_cnt   <= 0;
    end else if (o_ins_valid) begin
      stub_pend <= 1'b1;
      stub_cnt  <= $urandom_range(0, 4);
    end else if (stub_pend) begin
      if (ins_finish) begin
        ins_finish <= 1'b0;
      end else if (stub_cnt == 0) begin
        ins_finish <= 1'b1;
        ins_hit    <= resp_hit[cur_pix];
        ins_t      <= resp_t[cur_pix];
        ins_idx    <= resp_idx[cur_pix];
        stub_pend  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference direction: base + x*du + y*dv, each component mod 2^32.
  function automatic logic [95:0] dirOf(input logic [95:0] base, input logic [95:0] du,
                                        input logic [95:0] dv, input int x, input int y);
    logic [31:0] xx, yy;
    logic [95:0] r;
    xx = x;
    yy = y;
    for (int k = 0; k < 3; k++)
      r[32*k +: 32] = base[32*k +: 32] + xx * du[32*k +: 32] + yy * dv[32*k +: 32];
    return r;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ray"}, o_ins_ray, '0);
    checkOutput({tag, "_tri"}, o_ins_tri_cnt, '0);
    checkOutput({tag, "_ctrl"}, {o_ins_valid, res_if.o_res_valid, res_if.o_res_hit, o_busy, o_done}, '0);
    checkOutput({tag, "_res"}, {res_if.o_res_x, res_if.o_res_y, res_if.o_res_t, res_if.o_res_tri_index}, '0);
  endtask

  // Runs one frame. resp_mode 0: all miss except pixel 1 (hit, t=0x20000,
  // idx=7); 1: random responses. stall_pix holds ready low for 10 cycles on
  // that pixel's record. reset_pix pulses reset while that pixel waits for
  // tri_insector and abandons the frame.
  task automatic applyStimulus(input int w, input int h, input logic [31:0] tc,
                               input logic [95:0] eye, input logic [95:0] base,
                               input logic [95:0] du, input logic [95:0] dv,
                               input int resp_mode, input int stall_pix, input int reset_pix);
    int n = w * h;
    int p = 0, cyc = 0, stall = 0, ins_this = 0, pulses = 0;
    int budget = n * 40 + 60;
    bit stalled = 0;
    bit ex_hit;
    logic [31:0] ex_t, ex_idx;

    for (int i = 0; i < 64; i++) begin
      if (resp_mode == 1) begin
        resp_hit[i] = $urandom_range(0, 1);
        resp_t[i]   = $urandom;
        resp_idx[i] = $urandom;
      end else begin
        resp_hit[i] = (i == 1);
        resp_t[i]   = (i == 1) ? 32'h0002_0000 : MISS_T;
        resp_idx[i] = (i == 1) ? 32'd7 : 32'd0;
      end
    end
    cur_pix = 0;

    @(negedge i_clk);
    i_width = DIM_W'(w); i_height = DIM_W'(h); i_tri_cnt = tc;
    i_eye = eye; i_base = base; i_du = du; i_dv = dv;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;

    if (n == 0) begin
      checkOutput("zero_dim_done", o_done, 1'b1);
      checkOutput("zero_dim_idle", {o_busy, res_if.o_res_valid, o_ins_valid}, '0);
      @(negedge i_clk);
      checkOutput("zero_dim_done_clr", o_done, 1'b0);
      checkOutput("zero_dim_idle2", {o_busy, res_if.o_res_valid, o_ins_valid}, '0);
      return;
    end

    checkOutput("first_issue", o_ins_valid, tc != 0);
    checkOutput("first_emit", res_if.o_res_valid, tc == 0);
    checkOutput("first_busy", o_busy, 1'b1);

    while (p < n && cyc < budget) begin
      if (cyc > 0) @(negedge i_clk);
      cyc++;
      // Inputs are only meaningful at the accepted start; scramble them and
      // throw in a stray start to show the frame is unaffected.
      if (cyc == 2) begin
        i_width = DIM_W'(7); i_height = DIM_W'(9); i_tri_cnt = 32'd0;
        i_eye = {3{$urandom}}; i_base = {3{$urandom}}; i_du = {3{$urandom}}; i_dv = {3{$urandom}};
      end
      i_start = (cyc == 3);

      checkOutput("no_early_done", o_done, 1'b0);

      if (o_ins_valid) begin
        pulses++;
        checkOutput("ins_ray", o_ins_ray, {dirOf(base, du, dv, p % w, p / w), eye});
        checkOutput("ins_tri_cnt", o_ins_tri_cnt, tc);
        checkOutput("one_issue_per_pixel", ins_this, 0);
        ins_this++;
        if (p == reset_pix) begin
          i_start = 1'b0;
          @(negedge i_clk);
          @(negedge i_clk);
          i_rstn = 1'b0;
          @(negedge i_clk);
          i_rstn = 1'b1;
          checkAllZero("mid_reset");
          @(negedge i_clk);
          checkOutput("idle_after_reset", {o_busy, o_ins_valid, res_if.o_res_valid, o_done}, '0);
          return;
        end
      end

      if (res_if.o_res_valid) begin
        ex_hit = (tc == 0) ? 1'b0   : resp_hit[p];
        ex_t   = (tc == 0) ? MISS_T : resp_t[p];
        ex_idx = (tc == 0) ? 32'd0  : resp_idx[p];
        checkOutput("res_xy", {res_if.o_res_x, res_if.o_res_y}, {DIM_W'(p % w), DIM_W'(p / w)});
        checkOutput("res_hit", res_if.o_res_hit, ex_hit);
        checkOutput("res_t", res_if.o_res_t, ex_t);
        checkOutput("res_idx", res_if.o_res_tri_index, ex_idx);
        checkOutput("issues_before_record", ins_this, (tc == 0) ? 0 : 1);
        if (p == stall_pix && !stalled) begin
          stall = 10;
          stalled = 1;
        end
        if (stall > 0) begin
          res_if.i_res_ready = 1'b0;
          stall--;
        end else begin
          res_if.i_res_ready = ($urandom_range(0, 3) != 0);
        end
        if (res_if.i_res_ready) begin
          p++;
          ins_this = 0;
          cur_pix = p;
        end
      end else begin
        res_if.i_res_ready = 1'b0;
      end
    end
    i_start = 1'b0;

    if (p < n) checkOutput("frame_timeout_pixels", p, n);

    @(negedge i_clk);
    res_if.i_res_ready = 1'b0;
    checkOutput("frame_done", o_done, 1'b1);
    checkOutput("frame_idle", {o_busy, res_if.o_res_valid}, '0);
    checkOutput("issue_count", pulses, (tc == 0) ? 0 : n);
    @(negedge i_clk);
    checkOutput("done_single_pulse", o_done, 1'b0);
  endtask

  initial begin
    i_rstn = 1'b0;
    i_start = 1'b0;
    i_width = '0; i_height = '0; i_tri_cnt = '0;
    i_eye = '0; i_base = '0; i_du = '0; i_dv = '0;
    res_if.i_res_ready = 1'b0;

    @(negedge i_clk);
    @(negedge i_clk);
    checkAllZero("reset");
    i_rstn = 1'b1;
    @(negedge i_clk);

    $display("[TB] 2x2 frame, pixel 1 hits, 10-cycle stall on pixel 1");
    applyStimulus(2, 2, 32'd3, {32'h0003_0000, 32'h0001_0000, 32'h0002_0000},
                  {32'hFFFF_0000, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0000_8000},
                  {32'h0, 32'h0000_8000, 32'h0}, 0, 1, -1);

    $display("[TB] empty scene, 3x1 frame");
    applyStimulus(3, 1, 32'd0, {32'h1, 32'h2, 32'h3}, {32'h10, 32'h20, 32'h30},
                  {32'h1, 32'h1, 32'h1}, {32'h2, 32'h2, 32'h2}, 1, -1, -1);

    $display("[TB] zero-sized frames");
    applyStimulus(0, 3, 32'd5, '0, '0, '0, '0, 1, -1, -1);
    applyStimulus(2, 0, 32'd5, '0, '0, '0, '0, 1, -1, -1);

    $display("[TB] reset while pixel 2 waits for tri_insector");
    applyStimulus(3, 2, 32'd2, {3{32'h0000_1234}}, {32'h5, 32'h6, 32'h7},
                  {32'h0, 32'h0, 32'h100}, {32'h0, 32'h100, 32'h0}, 1, -1, 2);

    $display("[TB] clean frame after reset");
    applyStimulus(2, 2, 32'd3, {32'h0003_0000, 32'h0001_0000, 32'h0002_0000},
                  {32'hFFFF_0000, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0000_8000},
                  {32'h0, 32'h0000_8000, 32'h0}, 1, -1, -1);

    $display("[TB] x step wraps without saturation");
    applyStimulus(2, 1, 32'd1, '0, {32'h0, 32'h0, 32'h0000_0005},
                  {32'h0, 32'h0, 32'h7FFF_FFFF}, '0, 1, -1, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      applyStimulus($urandom_range(1, 4), $urandom_range(1, 3),
                    ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100)),
                    {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                    1, $urandom_range(0, 3), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
